// File: rtl/mem_write_arbiter_pkg.sv
// ============================================================================
// mem_write_arbiter_pkg: shared widths, FIFO/output entry struct, saturating add
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_write_arbiter_pkg;

  localparam int REG_WIDTH          = 32;
  localparam int DEF_MEM_ADDR_WIDTH = 16;

  // Address field is sized at the package default; narrower top-level
  // address widths are zero-extended into it.
  typedef struct packed {
    logic [DEF_MEM_ADDR_WIDTH-1:0] addr;
    logic [REG_WIDTH-1:0]          data;
  } mem_write_s;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [4:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + 17'(b);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_write_arbiter_write_fifo.sv
// ============================================================================
// write_fifo: single-core write-request FIFO, power-of-two depth
// Rev 1.0
// ============================================================================
`default_nettype none

module write_fifo
  import mem_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             push_i,
  input  mem_write_s       data_i,
  input  logic             pop_i,
  output mem_write_s       data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  mem_write_s       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Full is judged on the registered count, so a same-cycle pop never frees a slot for a push.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/mem_write_arbiter.sv
// ============================================================================
// mem_write_arbiter: per-core FIFOs drained round-robin into one memory write port
// Rev 1.0 -- optional drop counter enabled by MEM_WRITE_ARB_DROP_CNT_EN
// ============================================================================
`default_nettype none

module mem_write_arbiter
  import mem_write_arbiter_pkg::*;
#(
  parameter int NUM_CORES      = 4,
  parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
  parameter int FIFO_DEPTH     = 2
) (
  input  logic                                     clk_i,
  input  logic                                     reset_ni,
  input  logic [NUM_CORES-1:0]                     req_valid_i,
  input  logic [NUM_CORES-1:0][MEM_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_CORES-1:0][REG_WIDTH-1:0]      req_data_i,
  output logic [NUM_CORES-1:0]                     stall_o,
  output logic                                     mem_valid_o,
  output logic [MEM_ADDR_WIDTH-1:0]                mem_addr_o,
  output logic [REG_WIDTH-1:0]                     mem_data_o,
  input  logic                                     mem_ready_i,
  output logic [NUM_CORES-1:0]                     grant_o,
  output logic [15:0]                              drop_cnt_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int RR_W  = $clog2(NUM_CORES);

  mem_write_s                  fifo_head [NUM_CORES];
  logic [NUM_CORES-1:0]        fifo_empty;
  logic [NUM_CORES-1:0][CNT_W-1:0] fifo_cnt;
  logic [NUM_CORES-1:0]        fifo_pop;
`ifdef MEM_WRITE_ARB_DROP_CNT_EN
  logic [NUM_CORES-1:0]        fifo_full;
`endif

  logic                 out_valid_q, out_valid_d;
  mem_write_s           out_q, out_d;
  logic [NUM_CORES-1:0] grant_q, grant_d;
  logic [RR_W-1:0]      rr_q, rr_d;
  logic                 load;
  logic                 arb_found;
  logic [RR_W-1:0]      arb_winner;
  logic [RR_W:0]        arb_idx;

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_fifo
    mem_write_s entry;
    assign entry.addr = DEF_MEM_ADDR_WIDTH'(req_addr_i[c]);
    assign entry.data = req_data_i[c];

    write_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .push_i   (req_valid_i[c]),
      .data_i   (entry),
      .pop_i    (fifo_pop[c]),
      .data_o   (fifo_head[c]),
`ifdef MEM_WRITE_ARB_DROP_CNT_EN
      .full_o   (fifo_full[c]),
`else
      .full_o   (),
`endif
      .empty_o  (fifo_empty[c]),
      .count_o  (fifo_cnt[c])
    );

    // One slot of slack covers a write the core already has in flight.
    assign stall_o[c] = (fifo_cnt[c] >= CNT_W'(FIFO_DEPTH - 1));
  end

  assign load = ~out_valid_q | mem_ready_i;

  // First non-empty FIFO at or after rr_q, wrapping modulo NUM_CORES.
  always_comb begin
    arb_found  = 1'b0;
    arb_winner = '0;
    arb_idx    = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      arb_idx = {1'b0, rr_q} + (RR_W + 1)'(i);
      if (arb_idx >= (RR_W + 1)'(NUM_CORES)) arb_idx = arb_idx - (RR_W + 1)'(NUM_CORES);
      if (!arb_found && !fifo_empty[arb_idx[RR_W-1:0]]) begin
        arb_found  = 1'b1;
        arb_winner = arb_idx[RR_W-1:0];
      end
    end
  end

  always_comb begin
    fifo_pop    = '0;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    if (load) begin
      if (arb_found) begin
        fifo_pop[arb_winner] = 1'b1;
        out_valid_d          = 1'b1;
        out_d                = fifo_head[arb_winner];
        grant_d              = '0;
        grant_d[arb_winner]  = 1'b1;
        rr_d = (arb_winner == RR_W'(NUM_CORES - 1)) ? '0 : arb_winner + RR_W'(1);
      end else begin
        out_valid_d = 1'b0;
        grant_d     = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      grant_q     <= '0;
      rr_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
    end
  end

  assign mem_valid_o = out_valid_q;
  assign mem_addr_o  = MEM_ADDR_WIDTH'(out_q.addr);
  assign mem_data_o  = out_q.data;
  assign grant_o     = grant_q;

`ifdef MEM_WRITE_ARB_DROP_CNT_EN
  logic [NUM_CORES-1:0] drop_vec;
  logic [4:0]           drop_num;
  logic [15:0]          drop_cnt_q, drop_cnt_d;

  assign drop_vec = req_valid_i & fifo_full;

  always_comb begin
    drop_num = '0;
    for (int c = 0; c < NUM_CORES; c++) drop_num = drop_num + 5'(drop_vec[c]);
    drop_cnt_d = sat_add16(drop_cnt_q, drop_num);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) drop_cnt_q <= '0;
    else           drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

`default_nettype wire
